// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The entry PC width is fixed at FETCH_XLEN; fetch_stage is meant to be built with XLEN == FETCH_XLEN.
package fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_JAL = 7'b1101111;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic                  fault;
        logic                  pred_taken;
    } fetch_entry_t;

    // Sign-extended J-type immediate: imm[20|10:1|11|19:12] lives in instr[31:12].
    function automatic logic [31:0] jal_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; head is read from registered storage
// and reads as all-zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic                        pop,
    input  fetch_entry_t                din,
    output fetch_entry_t                head,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    fetch_entry_t    mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW:0]     count_reg;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == AW'(gi))) mem[gi] <= din;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures imem words into a small FIFO for decode.
// Optional JAL predecode/redirect of the fetch PC is enabled with FETCH_JAL_PREDECODE_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_fault,
    output logic            out_pred_taken
);

    fetch_state_e                state_reg, state_next;
    logic [XLEN-1:0]             pc_reg, pc_next;
    logic [XLEN-1:0]             seq_pc;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    fetch_entry_t                enq_entry, head_entry;
    logic                        enq, deq, aligned, pred_taken;

    assign aligned = (pc_reg[1:0] == 2'b00);
    assign deq     = !fifo_empty && out_ready;
    assign enq     = (state_reg == FETCH) && !redirect_valid && (!fifo_full || deq);

`ifdef FETCH_JAL_PREDECODE_EN
    assign pred_taken = aligned && (imem_rdata[6:0] == OPCODE_JAL);
    assign seq_pc     = pred_taken ? pc_reg + XLEN'($signed(jal_imm(imem_rdata)))
                                   : pc_reg + XLEN'(4);
`else
    // Stored pred_taken is constant 0, so its storage folds away.
    assign pred_taken = 1'b0;
    assign seq_pc     = pc_reg + XLEN'(4);
`endif

    always_comb begin
        enq_entry    = '0;
        enq_entry.pc = FETCH_XLEN'(pc_reg);
        if (aligned) begin
            enq_entry.instr      = imem_rdata;
            enq_entry.pred_taken = pred_taken;
        end else begin
            enq_entry.instr = NOP_INSTR;
            enq_entry.fault = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect_valid) begin
            state_next = FETCH;
            pc_next    = redirect_pc;
        end else if (enq) begin
            if (aligned) pc_next    = seq_pc;
            else         state_next = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (enq),
        .pop   (out_ready),
        .din   (enq_entry),
        .head  (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_addr      = pc_reg;
    assign out_valid      = (fifo_count != '0);
    assign out_pc         = XLEN'(head_entry.pc);
    assign out_instr      = head_entry.instr;
    assign out_fault      = head_entry.fault;
    assign out_pred_taken = head_entry.pred_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model, directed scenarios, random traffic.
module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_pc, out_instr;
    logic        redirect_valid, out_valid, out_ready, out_fault, out_pred_taken;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        logic        pred;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pc;
    bit          m_halt;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_fault(out_fault), .out_pred_taken(out_pred_taken)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0100_0413;
            32'h4:   return 32'h1010_0493;
            32'h8:   return 32'h0084_8933;
            32'h10:  return 32'h0080_006F;
            default: return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
            chk("out_fault", 32'(out_fault), 32'(q[0].fault));
            chk("out_pred_taken", 32'(out_pred_taken), 32'(q[0].pred));
        end
    endtask

    task automatic model_update(input logic rv, input logic [31:0] rpc, input logic rdy);
        bit          deq;
        bit          can;
        logic [31:0] w, nxt;
        logic [20:0] jimm;
        exp_t        e;
        deq = (q.size() != 0) && rdy;
        can = !m_halt && ((q.size() < DEPTH) || deq);
        if (deq)
            $display("[TB] deq pc=%h instr=%h fault=%0b pred=%0b", q[0].pc, q[0].instr, q[0].fault, q[0].pred);
        if (rv) begin
            q.delete();
            m_pc   = rpc;
            m_halt = 0;
        end else begin
            if (deq) void'(q.pop_front());
            if (can) begin
                if (m_pc[1:0] == 2'b00) begin
                    w   = mem_word(m_pc);
                    e   = '{m_pc, w, 1'b0, 1'b0};
                    nxt = m_pc + 32'd4;
`ifdef FETCH_JAL_PREDECODE_EN
                    if (w[6:0] == 7'h6F) begin
                        jimm   = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                        e.pred = 1'b1;
                        nxt    = m_pc + {{11{jimm[20]}}, jimm};
                    end
`endif
                    q.push_back(e);
                    m_pc = nxt;
                end else begin
                    q.push_back('{m_pc, 32'h0000_0013, 1'b1, 1'b0});
                    m_halt = 1;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance the model, land on the next falling edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        check_model();
        model_update(rv, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        q.delete();
        m_pc   = RESET_PC;
        m_halt = 0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst imem_addr", imem_addr, RESET_PC);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst out_instr", out_instr, 32'd0);
        chk("rst out_fault", 32'(out_fault), 32'd0);
        chk("rst out_pred", 32'(out_pred_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        #2;
        do_reset();

        // Streaming from reset
        step(0, 0, 1);
        chk("s1 pc", out_pc, 32'h0);
        chk("s1 instr", out_instr, 32'h0100_0413);
        step(0, 0, 1);
        chk("s2 pc", out_pc, 32'h4);
        chk("s2 instr", out_instr, 32'h1010_0493);
        step(0, 0, 1);
        chk("s3 pc", out_pc, 32'h8);
        chk("s3 instr", out_instr, 32'h0084_8933);
        chk("s3 fault", 32'(out_fault), 32'd0);

        // Backpressure
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("bp imem_addr", imem_addr, 32'h8);
        chk("bp out_pc", out_pc, 32'h0);
        step(0, 0, 1);
        chk("bp pc4", out_pc, 32'h4);
        step(0, 0, 1);
        chk("bp pc8", out_pc, 32'h8);

        // Redirect while full
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 32'h100, 0);
        chk("rd valid", 32'(out_valid), 32'd0);
        chk("rd imem_addr", imem_addr, 32'h100);
        step(0, 0, 0);
        chk("rd pc", out_pc, 32'h100);

        // Misaligned redirect halts until redirected again
        step(1, 32'h102, 0);
        step(0, 0, 0);
        chk("mis pc", out_pc, 32'h102);
        chk("mis instr", out_instr, 32'h0000_0013);
        chk("mis fault", 32'(out_fault), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        chk("mis halted", 32'(out_valid), 32'd0);
        chk("mis pc frozen", imem_addr, 32'h102);
        step(1, 32'h200, 1);
        step(0, 0, 1);
        chk("mis resume", out_pc, 32'h200);

        // PC wraps past the top of the address space
        step(1, 32'hFFFF_FFFC, 1);
        step(0, 0, 1);
        chk("wrap pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap imem_addr", imem_addr, 32'h0);

        // JAL predecode
        step(1, 32'h10, 1);
        step(0, 0, 1);
        chk("jal pc", out_pc, 32'h10);
`ifdef FETCH_JAL_PREDECODE_EN
        chk("jal pred", 32'(out_pred_taken), 32'd1);
        step(0, 0, 1);
        chk("jal target", out_pc, 32'h18);
`else
        chk("jal pred", 32'(out_pred_taken), 32'd0);
        step(0, 0, 1);
        chk("jal target", out_pc, 32'h14);
`endif

        // Async reset mid-stream, asserted between edges
        step(0, 0, 0);
        #2;
        do_reset();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) rpc = rpc + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) rpc = 32'hFFFF_FFF8;
            step(($urandom_range(0, 11) == 0), rpc, ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the PC, drives the memory's byte address and captures the combinational 32-bit little-endian word it returns.
- Buffers fetched words in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute, which flush in-flight fetches.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  XLEN  byte address to instruction memory; always equals the current PC.
- imem_rdata  in  32  instruction word at imem_addr, combinational, same cycle.
- redirect_valid  in  1  load a new PC this cycle and flush the buffer.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  buffer head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- out_fault  out  1  head entry is an instruction-address-misaligned fault.
- out_pred_taken  out  1  head entry was predicted taken (feature only; else 0).

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC, FIFO count = 0, state = FETCH.
  - out_valid = 0; out_pc, out_instr, out_fault and out_pred_taken read 0.
  - imem_addr = RESET_PC.
- States:
  - FETCH: fetch normally.
  - HALT: after a misaligned fetch; no enqueue, pc frozen.
  - Any redirect moves to FETCH.
- Outputs:
  - out_valid = (count != 0).
  - out_* come from registered FIFO head storage, never combinationally from imem_rdata.
- Dequeue: occurs when out_valid and out_ready.
- Enqueue in FETCH, no redirect, and (count < FIFO_DEPTH or dequeue this cycle):
  - pc[1:0] == 0: push {pc, imem_rdata, fault=0}; pc <= pc + 4, modulo 2^XLEN (wraps to 0).
  - pc[1:0] != 0: push {pc, 32'h0000_0013, fault=1}; pc unchanged; state <= HALT.
- FIFO full and no dequeue: no push; pc holds, so imem_addr holds.
- Latency: word at PC P visible on out_* the cycle after imem_addr = P; steady throughput 1 instruction/cycle.
- Redirect has highest priority below reset:
  - Same cycle: no enqueue; any dequeue still completes, but the FIFO is cleared at the edge.
  - Next edge: pc <= redirect_pc (full value, low bits kept), state <= FETCH.
  - Redirect-to-out_valid latency is 2 cycles.
- Simultaneous enqueue and dequeue while full is legal; count unchanged, order preserved.
- No loss or duplication under arbitrary out_ready patterns.

Optional Feature:
- Macro FETCH_JAL_PREDECODE_EN.
- Defined, on enqueue of a word with opcode 7'b1101111 (JAL):
  - next pc = pc + sign-extended J-immediate instead of pc + 4.
  - Entry stored with pred_taken = 1.
  - A misaligned predicted target faults on the next fetch per the normal rule.
  - An execute redirect always overrides.
- Undefined: no predecode, pred_taken storage removed, out_pred_taken tied 0.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013, OPCODE_JAL = 7'b1101111.
  - fetch_entry_t struct {pc, instr, fault, pred_taken}.
  - fetch_state_e enum {FETCH, HALT}.
  - J-immediate extraction function.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with flush, push, pop, count, full/empty; FIFO_DEPTH parameter.

Test Plan:
1. Streaming: RESET_PC=0; memory holds 01000413, 10100493, 00848933 at 0/4/8; out_ready=1 -> out_pc 0, 4, 8 on consecutive cycles from cycle 1 after reset release, matching instrs, fault=0.
2. Backpressure: out_ready=0 for 4 cycles after first valid -> count saturates at 2, imem_addr holds 8, out_pc stays 0; out_ready=1 -> out_pc 0, 4, 8 in order, no gaps or duplicates.
3. Redirect while full: buffer holds PCs 0/4, out_ready=0, redirect_pc=0x100 -> next cycle out_valid=0 and imem_addr=0x100; cycle after, out_pc=0x100.
4. Misalign: redirect to 0x102 -> one entry pc=0x102, instr=00000013, fault=1, then out_valid=0 indefinitely; redirect to 0x200 -> fetch resumes at 0x200.
5. Async reset mid-stream, asserted between edges -> out_valid=0 and imem_addr=RESET_PC immediately, before next clk edge.
6. FETCH_JAL_PREDECODE_EN: word 0080006F (jal x0,+8) at 0x10 -> entry 0x10 with pred_taken=1, next out_pc=0x18; macro undefined -> next out_pc=0x14, pred_taken=0.
